ttt_sweep_controller: RTL and testbench

- Drives the time-multiplexed TTT processor core from the other side of its interface.
- Accumulates incoming weighted token events per neuron, then on each slow tick sweeps neuron_id 0..NUM_PROCESSORS-1 to deliver pending tokens and assert clock_slow.
- Re-aligns the core's 2-cycle-late token_startstop responses to neuron ids, and emits start/stop events through a small FIFO with valid/ready handshake.

---
 rtl/ttt_pkg.sv | 23 ++
 rtl/ttt_sweep_controller_if.sv | 28 ++
 rtl/ttt_event_fifo.sv | 46 ++++
 rtl/ttt_sweep_controller.sv | 180 ++++++++++++++++++
 tb/tb_ttt_sweep_controller.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ttt_pkg.sv
// Shared types for the TTT sweep controller: response encodings, output event record
// and sweep FSM states.
package ttt_pkg;

  // Event ids are carried at a fixed width so the FIFO record does not depend on NUM_PROCESSORS.
  localparam int EV_ID_BITS = 8;

  localparam logic [1:0] TSS_START = 2'b10;
  localparam logic [1:0] TSS_STOP  = 2'b01;

  typedef struct packed {
    logic [EV_ID_BITS-1:0] neuron;
    logic                  start;
  } ttt_event_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    DRAIN1 = 2'd2,
    DRAIN2 = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/ttt_sweep_controller_if.sv
// Token-event input stream and start/stop event output stream of the sweep controller.
interface ttt_sweep_controller_if #(
  parameter int NEW_TOKENS_BITS = 4,
  parameter int ID_BITS         = 4
);
  // Both streams: a beat transfers on a rising edge where valid and ready are both high;
  // the sender holds valid and payload stable until that edge, ready may change freely.
  logic                              ev_valid;
  logic                              ev_ready;
  logic [ID_BITS-1:0]                ev_neuron;
  logic                              ev_bad;
  logic signed [NEW_TOKENS_BITS-1:0] ev_weight;

  logic                              out_valid;
  logic                              out_ready;
  logic [ID_BITS-1:0]                out_neuron;
  logic                              out_start;

  modport master (
    output ev_valid, ev_neuron, ev_bad, ev_weight, out_ready,
    input  ev_ready, out_valid, out_neuron, out_start
  );

  modport slave (
    input  ev_valid, ev_neuron, ev_bad, ev_weight, out_ready,
    output ev_ready, out_valid, out_neuron, out_start
  );
endinterface

// File: rtl/ttt_event_fifo.sv
// Synchronous FIFO of start/stop events; a push is taken when full if a pop
// happens on the same edge.
module ttt_event_fifo
  import ttt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  ttt_event_t push_data,
  input  logic       pop,
  output ttt_event_t head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  ttt_event_t     mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           wr_en;
  logic           rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ttt_sweep_controller.sv
// Accumulates weighted token events per neuron, sweeps them into the time-multiplexed
// TTT core on each tick, and turns the core's delayed start/stop replies into events.
module ttt_sweep_controller
  import ttt_pkg::*;
#(
  parameter int NEW_TOKENS_BITS = 4,
  parameter int NUM_PROCESSORS  = 10,
  parameter int FIFO_DEPTH      = 4,
  parameter int ID_BITS         = $clog2(NUM_PROCESSORS + 1)
) (
  input  logic                              clock_fast,
  input  logic                              reset_n,
  input  logic                              tick,
  ttt_sweep_controller_if.slave             bus,
  output logic [ID_BITS-1:0]                neuron_id,
  output logic signed [NEW_TOKENS_BITS-1:0] new_good_tokens,
  output logic signed [NEW_TOKENS_BITS-1:0] new_bad_tokens,
  output logic                              clock_slow,
  input  logic [1:0]                        token_startstop,
  output logic [NUM_PROCESSORS-1:0]         token_active,
  output logic                              busy,
  output logic [2:0]                        err_flags,
  output sweep_state_e                      sweep_state
);
  localparam int NB = NEW_TOKENS_BITS;
  localparam logic [ID_BITS-1:0] IDLE_ID = ID_BITS'(NUM_PROCESSORS);
  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_PROCESSORS - 1);
  localparam logic signed [NB-1:0] TOK_MAX = {1'b0, {(NB-1){1'b1}}};
  localparam logic signed [NB-1:0] TOK_MIN = {1'b1, {(NB-1){1'b0}}};

  function automatic logic signed [NB-1:0] sat_add(input logic signed [NB-1:0] a,
                                                   input logic signed [NB-1:0] b);
    logic signed [NB:0] sum;
    sum = $signed({a[NB-1], a}) + $signed({b[NB-1], b});
    if (sum[NB] != sum[NB-1]) return sum[NB] ? TOK_MIN : TOK_MAX;
    return sum[NB-1:0];
  endfunction

  sweep_state_e         state;
  logic signed [NB-1:0] pending_good [NUM_PROCESSORS];
  logic signed [NB-1:0] pending_bad  [NUM_PROCESSORS];
  logic signed [NB-1:0] acc_good     [NUM_PROCESSORS];
  logic signed [NB-1:0] acc_bad      [NUM_PROCESSORS];
  logic                 ev_fire, ev_bad_id;
  logic                 load_en;
  logic [ID_BITS-1:0]   load_idx;
  logic [ID_BITS-1:0]   sr_id [2];
  logic [1:0]           sr_vld;
  logic                 resp_start, resp_stop, resp_illegal;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  ttt_event_t           fifo_in, fifo_head;

  assign bus.ev_ready = reset_n;
  assign ev_fire      = bus.ev_valid && bus.ev_ready && (bus.ev_neuron <  IDLE_ID);
  assign ev_bad_id    = bus.ev_valid && bus.ev_ready && (bus.ev_neuron >= IDLE_ID);
  assign sweep_state  = state;

  always_comb begin
    for (int i = 0; i < NUM_PROCESSORS; i++) begin
      acc_good[i] = pending_good[i];
      acc_bad[i]  = pending_bad[i];
      if (ev_fire && bus.ev_neuron == ID_BITS'(i)) begin
        if (bus.ev_bad) acc_bad[i]  = sat_add(pending_bad[i],  bus.ev_weight);
        else            acc_good[i] = sat_add(pending_good[i], bus.ev_weight);
      end
    end
  end

  // The neuron presented next cycle is read (with this cycle's event folded in) and cleared
  // on this edge, so an event arriving while it is on the bus lands in the next sweep.
  always_comb begin
    load_en  = 1'b0;
    load_idx = '0;
    if (state == IDLE) begin
      load_en = tick;
    end else if (state == SWEEP && neuron_id != LAST_ID) begin
      load_en  = 1'b1;
      load_idx = neuron_id + 1'b1;
    end
  end

  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
        pending_good[i] <= '0;
        pending_bad[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
        if (load_en && load_idx == ID_BITS'(i)) begin
          pending_good[i] <= '0;
          pending_bad[i]  <= '0;
        end else begin
          pending_good[i] <= acc_good[i];
          pending_bad[i]  <= acc_bad[i];
        end
      end
    end
  end

  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      neuron_id       <= IDLE_ID;
      new_good_tokens <= '0;
      new_bad_tokens  <= '0;
      clock_slow      <= 1'b0;
      busy            <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tick) begin
          state      <= SWEEP;
          clock_slow <= 1'b1;
          busy       <= 1'b1;
        end
        SWEEP:  if (neuron_id == LAST_ID) state <= DRAIN1;
        DRAIN1: state <= DRAIN2;
        DRAIN2: begin
          state      <= IDLE;
          clock_slow <= 1'b0;
          busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (load_en) begin
        neuron_id       <= load_idx;
        new_good_tokens <= acc_good[load_idx];
        new_bad_tokens  <= acc_bad[load_idx];
      end else begin
        neuron_id       <= IDLE_ID;
        new_good_tokens <= '0;
        new_bad_tokens  <= '0;
      end
    end
  end

  // The core answers two cycles after an id is presented; only that cycle is meaningful.
  assign resp_start   = sr_vld[1] && (token_startstop == TSS_START);
  assign resp_stop    = sr_vld[1] && (token_startstop == TSS_STOP);
  assign resp_illegal = sr_vld[1] && (token_startstop == 2'b11);
  assign fifo_push    = resp_start || resp_stop;
  assign fifo_pop     = bus.out_valid && bus.out_ready;
  assign fifo_in.neuron = EV_ID_BITS'(sr_id[1]);
  assign fifo_in.start  = resp_start;

  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) begin
      sr_id[0]     <= '0;
      sr_id[1]     <= '0;
      sr_vld       <= '0;
      token_active <= '0;
      err_flags    <= '0;
    end else begin
      sr_id[0]  <= neuron_id;
      sr_id[1]  <= sr_id[0];
      sr_vld[0] <= (neuron_id < IDLE_ID);
      sr_vld[1] <= sr_vld[0];
      if (fifo_push) token_active[sr_id[1]] <= resp_start;
      if (tick && state != IDLE)                err_flags[0] <= 1'b1;
      if (fifo_push && fifo_full && !fifo_pop)  err_flags[1] <= 1'b1;
      if (ev_bad_id || resp_illegal)            err_flags[2] <= 1'b1;
    end
  end

  ttt_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clock_fast),
    .rst_n     (reset_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.out_valid  = !fifo_empty;
  assign bus.out_neuron = fifo_head.neuron[ID_BITS-1:0];
  assign bus.out_start  = fifo_head.start;

endmodule

// File: tb/tb_ttt_sweep_controller.sv
// Bench for ttt_sweep_controller: directed scenarios plus random traffic, checked every
// cycle against a sweep-position reference model with an expected-event queue.
module tb_ttt_sweep_controller;
  import ttt_pkg::*;

  localparam int NB    = 4;
  localparam int NP    = 10;
  localparam int DEPTH = 4;
  localparam int IDB   = 4;
  localparam int W     = IDB + 1;

  // ---------------- clock / reset / DUT ----------------
  logic                 clock_fast = 1'b0;
  logic                 reset_n    = 1'b0;
  logic                 tick       = 1'b0;
  logic [1:0]           token_startstop = 2'b00;
  logic [IDB-1:0]       neuron_id;
  logic signed [NB-1:0] new_good_tokens, new_bad_tokens;
  logic                 clock_slow, busy;
  logic [NP-1:0]        token_active;
  logic [2:0]           err_flags;
  sweep_state_e         sweep_state;

  ttt_sweep_controller_if #(.NEW_TOKENS_BITS(NB), .ID_BITS(IDB)) bus ();

  ttt_sweep_controller #(
    .NEW_TOKENS_BITS(NB), .NUM_PROCESSORS(NP), .FIFO_DEPTH(DEPTH), .ID_BITS(IDB)
  ) dut (
    .clock_fast      (clock_fast),
    .reset_n         (reset_n),
    .tick            (tick),
    .bus             (bus),
    .neuron_id       (neuron_id),
    .new_good_tokens (new_good_tokens),
    .new_bad_tokens  (new_bad_tokens),
    .clock_slow      (clock_slow),
    .token_startstop (token_startstop),
    .token_active    (token_active),
    .busy            (busy),
    .err_flags       (err_flags),
    .sweep_state     (sweep_state)
  );

  always #5 clock_fast = ~clock_fast;

  // ---------------- reference model ----------------
  int            m_pg[NP], m_pb[NP];
  int            m_pos;            // -1 idle, else cycles since the sweep began (0..NP+1)
  int            e_id, e_good, e_bad;
  bit            e_cs;
  logic [NP-1:0] m_active;
  logic [2:0]    m_err;
  logic [W-1:0]  exp_q[$];
  int            hist[$];          // ids presented in recent cycles

  int            checks = 0, failures = 0;
  logic [W-1:0]  dut_pops[$];
  int            cs_count;
  int            cap_good[NP], cap_bad[NP];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 7)  return 7;
    if (v < -8) return -8;
    return v;
  endfunction

  function automatic int due_id();
    return (hist.size() == 2) ? hist[0] : NP;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin m_pg[i] = 0; m_pb[i] = 0; end
    m_pos = -1; e_id = NP; e_good = 0; e_bad = 0; e_cs = 0;
    m_active = '0; m_err = '0;
    exp_q.delete(); hist.delete();
  endtask

  task automatic model_step();
    int rid, n;
    bit st;
    hist.push_back(e_id);
    rid = NP;
    if (hist.size() > 2) rid = hist.pop_front();
    if (bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (rid < NP) begin
      if (token_startstop == 2'b10 || token_startstop == 2'b01) begin
        st = (token_startstop == 2'b10);
        m_active[rid] = st;
        if (exp_q.size() < DEPTH) exp_q.push_back({rid[IDB-1:0], st});
        else m_err[1] = 1'b1;
      end else if (token_startstop == 2'b11) begin
        m_err[2] = 1'b1;
      end
    end
    if (bus.ev_valid) begin
      n = int'(bus.ev_neuron);
      if (n >= NP) m_err[2] = 1'b1;
      else if (bus.ev_bad) m_pb[n] = clamp(m_pb[n] + int'(bus.ev_weight));
      else                 m_pg[n] = clamp(m_pg[n] + int'(bus.ev_weight));
    end
    if (m_pos < 0) begin
      if (tick) m_pos = 0;
    end else begin
      if (tick) m_err[0] = 1'b1;
      m_pos++;
      if (m_pos > NP + 1) m_pos = -1;
    end
    e_cs = (m_pos >= 0);
    if (m_pos >= 0 && m_pos < NP) begin
      e_id = m_pos; e_good = m_pg[m_pos]; e_bad = m_pb[m_pos];
      m_pg[m_pos] = 0; m_pb[m_pos] = 0;
    end else begin
      e_id = NP; e_good = 0; e_bad = 0;
    end
  endtask

  task automatic compare();
    chk("ev_ready",     int'(bus.ev_ready), 1);
    chk("neuron_id",    int'(neuron_id), e_id);
    chk("new_good",     int'(new_good_tokens), e_good);
    chk("new_bad",      int'(new_bad_tokens), e_bad);
    chk("clock_slow",   int'(clock_slow), int'(e_cs));
    chk("busy",         int'(busy), int'(e_cs));
    chk("token_active", int'(token_active), int'(m_active));
    chk("err_flags",    int'(err_flags), int'(m_err));
    chk("out_valid",    int'(bus.out_valid), int'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("out_head", int'({bus.out_neuron, bus.out_start}), int'(exp_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    if (bus.out_valid && bus.out_ready) dut_pops.push_back({bus.out_neuron, bus.out_start});
    if (clock_slow) cs_count++;
    if (neuron_id < IDB'(NP)) begin
      cap_good[neuron_id] = int'(new_good_tokens);
      cap_bad[neuron_id]  = int'(new_bad_tokens);
    end
    model_step();
    @(posedge clock_fast);
    #1;
    compare();
    tick = 1'b0;
    bus.ev_valid = 1'b0;
  endtask

  task automatic set_ev(input int n, input bit bad, input int w);
    bus.ev_neuron = n[IDB-1:0];
    bus.ev_bad    = bad;
    bus.ev_weight = w[NB-1:0];
    bus.ev_valid  = 1'b1;
  endtask

  task automatic clear_caps();
    cs_count = 0;
    for (int i = 0; i < NP; i++) begin cap_good[i] = -99; cap_bad[i] = -99; end
  endtask

  // Tick, then answer `code` for every id in [lo,hi] exactly when it is due.
  task automatic sweep_respond(input int lo, input int hi, input logic [1:0] code);
    clear_caps();
    tick = 1'b1;
    for (int k = 0; k < 14; k++) begin
      token_startstop = (due_id() >= lo && due_id() <= hi) ? code : 2'b00;
      cycle();
    end
    token_startstop = 2'b00;
  endtask

  task automatic chk_pop(input string name, input int idx, input logic [W-1:0] exp);
    if (idx < dut_pops.size()) chk(name, int'(dut_pops[idx]), int'(exp));
    else chk({name, "_missing"}, dut_pops.size(), idx + 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.ev_valid = 1'b0; bus.ev_neuron = '0; bus.ev_bad = 1'b0; bus.ev_weight = '0;
    bus.out_ready = 1'b1;
    model_reset();
    clear_caps();
    repeat (3) @(posedge clock_fast);
    #1;
    chk("reset_neuron_id", int'(neuron_id), 10);
    chk("reset_busy",      int'(busy), 0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_err",       int'(err_flags), 0);
    chk("reset_ev_ready",  int'(bus.ev_ready), 0);
    @(negedge clock_fast);
    reset_n = 1'b1;
    cycle();
    cycle();

    // accumulation with saturation
    set_ev(3, 1'b0, 4); cycle();
    set_ev(3, 1'b0, 4); cycle();
    sweep_respond(0, -1, 2'b00);
    chk("acc_delivered_3", cap_good[3], 7);
    chk("acc_other_2",     cap_good[2], 0);
    chk("sweep_len",       cs_count, 12);

    // start response for neuron 5
    dut_pops.delete();
    sweep_respond(5, 5, 2'b10);
    chk("pending_3_cleared", cap_good[3], 0);
    chk("start_active_5",    int'(token_active[5]), 1);
    chk("start_pop_count",   dut_pops.size(), 1);
    chk_pop("start_event", 0, {4'd5, 1'b1});
    dut_pops.delete();
    token_startstop = 2'b10;
    repeat (6) cycle();
    token_startstop = 2'b00;
    chk("held_in_idle", dut_pops.size() + int'(bus.out_valid), 0);

    // stop response for neuron 5
    dut_pops.delete();
    sweep_respond(5, 5, 2'b01);
    chk("stop_active_5",  int'(token_active[5]), 0);
    chk_pop("stop_event", 0, {4'd5, 1'b0});
    chk("stop_sweep_len", cs_count, 12);

    // backpressure: five starts into a four-entry FIFO
    bus.out_ready = 1'b0;
    dut_pops.delete();
    sweep_respond(0, 4, 2'b10);
    chk("overflow_err",    int'(err_flags[1]), 1);
    chk("overflow_active", int'(token_active[4]), 1);
    bus.out_ready = 1'b1;
    repeat (6) cycle();
    chk("bp_pop_count", dut_pops.size(), 4);
    for (int i = 0; i < 4; i++) chk_pop("bp_order", i, {i[IDB-1:0], 1'b1});

    // collisions: tick while busy, same-cycle event, bad id
    clear_caps();
    tick = 1'b1;
    cycle();
    for (int k = 0; k < 13; k++) begin
      if (k == 4) tick = 1'b1;
      if (e_id == 2) set_ev(2, 1'b1, 1);
      if (k == 8) set_ev(12, 1'b0, 3);
      cycle();
    end
    chk("tick_busy_err",    int'(err_flags[0]), 1);
    chk("tick_busy_len",    cs_count, 12);
    chk("same_cycle_bad_2", cap_bad[2], 0);
    chk("bad_id_err",       int'(err_flags[2]), 1);
    sweep_respond(0, -1, 2'b00);
    chk("next_sweep_bad_2", cap_bad[2], 1);

    // reset in the middle of a sweep with events queued
    bus.out_ready = 1'b0;
    tick = 1'b1;
    cycle();
    for (int k = 0; k < 20 && e_id != 6; k++) begin
      token_startstop = (due_id() <= 3) ? 2'b10 : 2'b00;
      cycle();
    end
    token_startstop = 2'b00;
    chk("pre_reset_id",    int'(neuron_id), 6);
    chk("pre_reset_valid", int'(bus.out_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_id",     int'(neuron_id), 10);
    chk("mid_reset_cs",     int'(clock_slow), 0);
    chk("mid_reset_busy",   int'(busy), 0);
    chk("mid_reset_good",   int'(new_good_tokens), 0);
    chk("mid_reset_valid",  int'(bus.out_valid), 0);
    chk("mid_reset_active", int'(token_active), 0);
    chk("mid_reset_err",    int'(err_flags), 0);
    model_reset();
    @(negedge clock_fast);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) cycle();

    // random traffic
    for (int k = 0; k < 800; k++) begin
      int r;
      tick = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) == 1)
        set_ev(int'($urandom_range(0, 12)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      r = int'($urandom_range(0, 19));
      token_startstop = (r < 3) ? 2'b10 : (r < 6) ? 2'b01 : (r == 6) ? 2'b11 : 2'b00;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
